// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-chip-select SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  function automatic int unsigned div_cnt_width(input int unsigned div_half);
    return $clog2(div_half + 1);
  endfunction

  localparam int unsigned DIV_HALF_DEFAULT = 4;
  localparam int unsigned DIV_CNT_WIDTH    = div_cnt_width(DIV_HALF_DEFAULT);

  // Effective transfer length: requested count limited to the datapath width.
  function automatic int unsigned clamp_bits(input int unsigned n, input int unsigned data_width);
    return (n > data_width) ? data_width : n;
  endfunction

endpackage

// File: rtl/spi_multi_cs_master_if.sv
// Host request/response and SPI pin bundle for spi_multi_cs_master.
interface spi_multi_cs_master_if #(
  parameter int unsigned DATA_WIDTH      = 70,
  parameter int unsigned BIT_COUNT_WIDTH = 8,
  parameter int unsigned NUM_CS          = 4,
  parameter int unsigned CS_SEL_WIDTH    = 2
);

  logic                       start;
  logic [CS_SEL_WIDTH-1:0]    cs_sel;
  logic                       lsb_first;
  logic [BIT_COUNT_WIDTH-1:0] num_of_bit;
  logic [DATA_WIDTH-1:0]      data_in;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [NUM_CS-1:0]          spi_cs_n;
  logic                       spi_sck;
  logic                       spi_sdo;
  logic                       spi_sdi;

  modport master (
    input  start, cs_sel, lsb_first, num_of_bit, data_in, spi_sdi,
    output rd_data, busy, done, err, spi_cs_n, spi_sck, spi_sdo
  );

  modport slave (
    output start, cs_sel, lsb_first, num_of_bit, data_in, spi_sdi,
    input  rd_data, busy, done, err, spi_cs_n, spi_sck, spi_sdo
  );

endinterface

// File: rtl/spi_half_tick.sv
// SCK half-period timer: one-cycle tick every DIV_HALF enabled cycles, restarted on state entry.
module spi_half_tick
  import spi_pkg::*;
#(
  parameter int unsigned DIV_HALF = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = div_cnt_width(DIV_HALF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_HALF - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || !en || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_multi_cs_master.sv
// Full-duplex SPI master (CPHA=0) with decoded chip selects, runtime bit count and bit order.
module spi_multi_cs_master
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 70,
  parameter int unsigned BIT_COUNT_WIDTH = 8,
  parameter int unsigned NUM_CS          = 4,
  parameter int unsigned CS_SEL_WIDTH    = 2,
  parameter int unsigned DIV_HALF        = 4,
  parameter bit          SPI_CPOL        = 1'b0
) (
  input logic                   clk,
  input logic                   reset_n,
  spi_multi_cs_master_if.master bus
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

  state_t                     state_q, state_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [NUM_CS-1:0]          cs_n_q, cs_n_d;
  logic                       sck_q, sck_d;
  logic                       sdo_q, sdo_d;
  logic [DATA_WIDTH-1:0]      rd_q, rd_d;
  logic [DATA_WIDTH-1:0]      tx_q, tx_d;
  logic [DATA_WIDTH-1:0]      rx_q, rx_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [BIT_COUNT_WIDTH-1:0] left_q, left_d;
  logic                       lsb_q, lsb_d;

  logic [BIT_COUNT_WIDTH-1:0] n_eff;
  logic [IDX_W-1:0]           first_idx;
  logic [IDX_W-1:0]           next_idx;
  logic                       sel_bad;
  logic                       sck_active;
  logic                       tick_c;

  assign n_eff     = BIT_COUNT_WIDTH'(clamp_bits(32'(bus.num_of_bit), DATA_WIDTH));
  assign first_idx = bus.lsb_first ? '0 : IDX_W'(32'(n_eff) - 32'd1);
  assign next_idx  = lsb_q ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
  assign sel_bad   = 32'(bus.cs_sel) >= NUM_CS;
  assign sck_active = (sck_q != SPI_CPOL);

  spi_half_tick #(
    .DIV_HALF (DIV_HALF)
  ) u_half_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q != IDLE),
    .clear   (state_d != state_q),
    .tick_c  (tick_c)
  );

  // Next-state and next-output logic; tx/rx share one bit index since both map bit k to [idx].
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    rd_d    = rd_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    left_d  = left_q;
    lsb_d   = lsb_q;

    case (state_q)
      IDLE: begin
        // The DONE/ERR cycle itself never accepts, so a held START retriggers one cycle later.
        if (bus.start && !done_q && !err_q) begin
          if (sel_bad) begin
            err_d = 1'b1;
          end else if (n_eff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
            busy_d  = 1'b1;
            cs_n_d  = ~(NUM_CS'(1) << bus.cs_sel);
            tx_d    = bus.data_in;
            rx_d    = '0;
            lsb_d   = bus.lsb_first;
            left_d  = n_eff;
            idx_d   = first_idx;
            sdo_d   = bus.data_in[first_idx];
          end
        end
      end
      SETUP: begin
        if (tick_c) begin
          state_d     = SHIFT;
          sck_d       = ~SPI_CPOL;
          rx_d[idx_q] = bus.spi_sdi;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (sck_active) begin
            sck_d = SPI_CPOL;
            // Idle half of the final period is spent in HOLD.
            if (left_q == BIT_COUNT_WIDTH'(1)) begin
              state_d = HOLD;
            end else begin
              left_d = left_q - BIT_COUNT_WIDTH'(1);
              idx_d  = next_idx;
              sdo_d  = tx_q[next_idx];
            end
          end else begin
            sck_d       = ~SPI_CPOL;
            rx_d[idx_q] = bus.spi_sdi;
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          state_d = GAP;
          cs_n_d  = '1;
        end
      end
      GAP: begin
        if (tick_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rd_d    = rx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_n_q  <= '1;
      sck_q   <= SPI_CPOL;
      sdo_q   <= 1'b0;
      rd_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      lsb_q   <= lsb_d;
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_sck  = sck_q;
  assign bus.spi_sdo  = sdo_q;

endmodule

// File: tb/tb_spi_multi_cs_master.sv
// Directed bench for spi_multi_cs_master: DIV_HALF=2, 70-bit datapath, 4 chip selects, 3-bit select.
module tb_spi_multi_cs_master;

  localparam int unsigned DW  = 70;
  localparam int unsigned BCW = 8;
  localparam int unsigned NCS = 4;
  localparam int unsigned CSW = 3;
  localparam int unsigned DH  = 2;

  logic clk;
  logic reset_n;
  logic loop_en;
  logic sdi_val;

  int n_cmp;
  int n_err;

  spi_multi_cs_master_if #(
    .DATA_WIDTH      (DW),
    .BIT_COUNT_WIDTH (BCW),
    .NUM_CS          (NCS),
    .CS_SEL_WIDTH    (CSW)
  ) bus ();

  spi_multi_cs_master #(
    .DATA_WIDTH      (DW),
    .BIT_COUNT_WIDTH (BCW),
    .NUM_CS          (NCS),
    .CS_SEL_WIDTH    (CSW),
    .DIV_HALF        (DH),
    .SPI_CPOL        (1'b0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  assign bus.spi_sdi = loop_en ? bus.spi_sdo : sdi_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request issued in cycle 0; inputs scrambled in cycle 1; watches until DONE or budget.
  task automatic xfer(input logic [CSW-1:0] sel, input logic lsb, input logic [BCW-1:0] nb,
                      input logic [DW-1:0] din, input int budget, input int pulse_at,
                      output int done_cyc, output int err_cyc, output int pulses,
                      output logic [DW-1:0] stream, output logic [NCS-1:0] cs_and,
                      output bit busy_seen);
    logic prev_sck;
    @(posedge clk); #1;
    bus.cs_sel     = sel;
    bus.lsb_first  = lsb;
    bus.num_of_bit = nb;
    bus.data_in    = din;
    bus.start      = 1'b1;
    done_cyc  = -1;
    err_cyc   = -1;
    pulses    = 0;
    stream    = '0;
    cs_and    = '1;
    busy_seen = 1'b0;
    prev_sck  = bus.spi_sck;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      bus.start = (c == pulse_at);
      if (c == 1) begin
        bus.data_in    = ~din;
        bus.num_of_bit = 8'd3;
        bus.cs_sel     = '0;
        bus.lsb_first  = ~lsb;
      end
      cs_and    = cs_and & bus.spi_cs_n;
      busy_seen = busy_seen | bus.busy;
      if (bus.spi_sck && !prev_sck) begin
        stream = {stream[DW-2:0], bus.spi_sdo};
        pulses++;
      end
      prev_sck = bus.spi_sck;
      if (bus.err && err_cyc < 0) err_cyc = c;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int              dc, ec, np, nd, d1, d2, run, last_lo;
    logic [DW-1:0]   st;
    logic [NCS-1:0]  ca;
    bit              bs;
    logic [DW-1:0]   ones;

    n_cmp = 0;
    n_err = 0;
    ones  = '1;
    reset_n        = 1'b0;
    loop_en        = 1'b1;
    sdi_val        = 1'b0;
    bus.start      = 1'b0;
    bus.cs_sel     = '0;
    bus.lsb_first  = 1'b0;
    bus.num_of_bit = '0;
    bus.data_in    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 70'(bus.spi_cs_n), 70'hF);
    check("rst_sck",  70'(bus.spi_sck), 70'h0);
    check("rst_sdo",  70'(bus.spi_sdo), 70'h0);
    check("rst_rd",   bus.rd_data, 70'h0);
    check("rst_flags", 70'({bus.busy, bus.done, bus.err}), 70'h0);
    @(negedge clk) reset_n = 1'b1;

    // MSB-first loopback of 0xA5 on CS1
    xfer(3'd1, 1'b0, 8'd8, 70'hA5, 100, 0, dc, ec, np, st, ca, bs);
    check("t1_done_cyc", 70'(dc), 70'd37);
    check("t1_pulses",   70'(np), 70'd8);
    check("t1_sdo",      st, 70'hA5);
    check("t1_rd",       bus.rd_data, 70'hA5);
    check("t1_cs",       70'(ca), 70'b1101);
    check("t1_busy_end", 70'(bus.busy), 70'h0);

    // LSB-first loopback, 12 bits on CS2, upper input bits ignored
    xfer(3'd2, 1'b1, 8'd12, 70'hFFF0A6B, 100, 0, dc, ec, np, st, ca, bs);
    check("lsb12_done_cyc", 70'(dc), 70'd53);
    check("lsb12_pulses",   70'(np), 70'd12);
    check("lsb12_sdo",      st, 70'hD65);
    check("lsb12_rd",       bus.rd_data, 70'hA6B);
    check("lsb12_cs",       70'(ca), 70'b1011);

    // MSB-first, 5 bits on CS3
    xfer(3'd3, 1'b0, 8'd5, 70'h3F3, 100, 0, dc, ec, np, st, ca, bs);
    check("msb5_done_cyc", 70'(dc), 70'd25);
    check("msb5_sdo",      st, 70'h13);
    check("msb5_rd",       bus.rd_data, 70'h13);
    check("msb5_cs",       70'(ca), 70'b0111);

    // Full width, LSB-first, SDI tied high
    loop_en = 1'b0;
    sdi_val = 1'b1;
    xfer(3'd0, 1'b1, 8'd70, 70'h0, 400, 0, dc, ec, np, st, ca, bs);
    check("full_done_cyc", 70'(dc), 70'd285);
    check("full_pulses",   70'(np), 70'd70);
    check("full_sdo",      st, 70'h0);
    check("full_rd",       bus.rd_data, ones);
    check("full_cs",       70'(ca), 70'b1110);

    // Zero-length request: immediate DONE, no CS, RD_DATA kept
    xfer(3'd0, 1'b0, 8'd0, 70'h5, 20, 0, dc, ec, np, st, ca, bs);
    check("n0_done_cyc", 70'(dc), 70'd1);
    check("n0_cs",       70'(ca), 70'hF);
    check("n0_pulses",   70'(np), 70'd0);
    check("n0_busy",     70'(bs), 70'd0);
    check("n0_rd_kept",  bus.rd_data, ones);

    // Oversized count clamps to 70, SDI tied low
    sdi_val = 1'b0;
    xfer(3'd0, 1'b0, 8'd200, ones, 400, 0, dc, ec, np, st, ca, bs);
    check("n200_done_cyc", 70'(dc), 70'd285);
    check("n200_pulses",   70'(np), 70'd70);
    check("n200_sdo",      st, ones);
    check("n200_rd",       bus.rd_data, 70'h0);

    // Invalid select: ERR only
    xfer(3'd5, 1'b0, 8'd8, 70'hA5, 20, 0, dc, ec, np, st, ca, bs);
    check("err_cyc",    70'(ec), 70'd1);
    check("err_done",   70'(dc), 70'hFFFFFFFFFFFFFFFFFF);
    check("err_cs",     70'(ca), 70'hF);
    check("err_pulses", 70'(np), 70'd0);
    check("err_busy",   70'(bs), 70'd0);

    // START re-pulsed mid-SHIFT is ignored
    loop_en = 1'b1;
    xfer(3'd1, 1'b0, 8'd8, 70'h3C, 100, 10, dc, ec, np, st, ca, bs);
    check("repulse_done_cyc", 70'(dc), 70'd37);
    check("repulse_rd",       bus.rd_data, 70'h3C);
    count_dones(60, nd);
    check("repulse_extra_done", 70'(nd), 70'd0);

    // START held: back-to-back transfers
    @(posedge clk); #1;
    bus.cs_sel     = 3'd1;
    bus.lsb_first  = 1'b0;
    bus.num_of_bit = 8'd8;
    bus.data_in    = 70'hA5;
    bus.start      = 1'b1;
    d1 = -1; d2 = -1; run = -1; last_lo = 0;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (bus.spi_cs_n != 4'hF) begin
        if (d1 >= 0 && run < 0) run = c - last_lo - 1;
        last_lo = c;
      end
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = c;
        end else begin
          d2 = c;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    check("held_done1", 70'(d1), 70'd37);
    check("held_done2", 70'(d2), 70'd75);
    check("held_cs_gap", 70'(run), 70'd4);
    check("held_rd", bus.rd_data, 70'hA5);
    count_dones(20, nd);
    check("held_no_third", 70'(nd), 70'd0);

    // Reset during SHIFT of bit 3
    @(posedge clk); #1;
    bus.cs_sel     = 3'd1;
    bus.lsb_first  = 1'b0;
    bus.num_of_bit = 8'd8;
    bus.data_in    = 70'h5A;
    bus.start      = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("rst_mid_sck_pre", 70'(bus.spi_sck), 70'h1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_cs_n", 70'(bus.spi_cs_n), 70'hF);
    check("rst_mid_sck",  70'(bus.spi_sck), 70'h0);
    check("rst_mid_rd",   bus.rd_data, 70'h0);
    check("rst_mid_busy", 70'(bus.busy), 70'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    count_dones(50, nd);
    check("rst_mid_no_done", 70'(nd), 70'd0);

    xfer(3'd1, 1'b0, 8'd8, 70'hA5, 100, 0, dc, ec, np, st, ca, bs);
    check("post_rst_done_cyc", 70'(dc), 70'd37);
    check("post_rst_rd",       bus.rd_data, 70'hA5);
    check("post_rst_cs",       70'(ca), 70'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
